// File: rtl/cordic_hyp_pkg.sv
// Shared constants and types for the two-client hyperbolic CORDIC scheduler.
// All angles and gains are Q16.16; PRE uses the expanded-range factors 1-2^(k-7).
package cordic_hyp_pkg;

  localparam int Q_W = 32;

  // 1/K over all 24 micro-rotations (6 PRE + 18 MAIN), in Q16.16
  localparam logic signed [Q_W-1:0] KINV_Q16 = 32'sd130334133;

  localparam logic signed [Q_W-1:0] PRE_GAIN [0:5] = '{
    32'sd65024, 32'sd64512, 32'sd63488, 32'sd61440, 32'sd57344, 32'sd49152
  };

  localparam logic signed [Q_W-1:0] PRE_ATANH [0:5] = '{
    32'sd181576, 32'sd158734, 32'sd135762, 32'sd112525, 32'sd88737, 32'sd63764
  };

  // MAIN index i rotates by 2^-(i+1)
  localparam logic signed [Q_W-1:0] MAIN_GAIN [0:15] = '{
    32'sd32768, 32'sd16384, 32'sd8192, 32'sd4096, 32'sd2048, 32'sd1024, 32'sd512, 32'sd256,
    32'sd128,   32'sd64,    32'sd32,   32'sd16,   32'sd8,    32'sd4,    32'sd2,   32'sd1
  };

  localparam logic signed [Q_W-1:0] MAIN_ATANH [0:15] = '{
    32'sd35999, 32'sd16739, 32'sd8235, 32'sd4101, 32'sd2049, 32'sd1024, 32'sd512, 32'sd256,
    32'sd128,   32'sd64,    32'sd32,   32'sd16,   32'sd8,    32'sd4,    32'sd2,   32'sd1
  };

  localparam logic [3:0] REP_IDX_A = 4'd3;
  localparam logic [3:0] REP_IDX_B = 4'd12;

  localparam int PRE_STEPS  = 6;
  localparam int MAIN_STEPS = 18;

  typedef enum logic [1:0] {IDLE, PRE, MAIN, DONE} state_t;

endpackage

// File: rtl/cordic_hyp_step.sv
// One combinational hyperbolic micro-rotation: (x,y,z) -> (x',y',z') plus the next direction.
module cordic_hyp_step
  import cordic_hyp_pkg::*;
(
  input  logic signed [Q_W-1:0] x,
  input  logic signed [Q_W-1:0] y,
  input  logic signed [Q_W-1:0] z,
  input  logic                  s_pos,
  input  logic signed [Q_W-1:0] gain,
  input  logic signed [Q_W-1:0] atanh,
  output logic signed [Q_W-1:0] x_n,
  output logic signed [Q_W-1:0] y_n,
  output logic signed [Q_W-1:0] z_n,
  output logic                  s_n
);

  logic signed [Q_W-1:0] xt;
  logic signed [Q_W-1:0] yt;

  // full 64-bit product, arithmetic shift back to Q16.16, truncate to 32 bits
  assign xt = 32'((64'(x) * 64'(gain)) >>> 16);
  assign yt = 32'((64'(y) * 64'(gain)) >>> 16);

  assign x_n = s_pos ? (x + yt) : (x - yt);
  assign y_n = s_pos ? (y + xt) : (y - xt);
  assign z_n = s_pos ? (z - atanh) : (z + atanh);
  assign s_n = (z_n > 32'sd0);

endmodule

// File: rtl/cordic_hyp_sched.sv
// Round-robin two-client front end around an iterative hyperbolic CORDIC
// producing cosh, sinh and a saturated exp = cosh + sinh, one result per 26 cycles.
module cordic_hyp_sched
  import cordic_hyp_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0,
  input  logic                  req1,
  input  logic signed [Q_W-1:0] angle0,
  input  logic signed [Q_W-1:0] angle1,
  output logic [1:0]            gnt,
  output logic                  busy,
  output logic                  res_valid,
  output logic                  res_id,
  output logic signed [Q_W-1:0] cosh,
  output logic signed [Q_W-1:0] sinh,
  output logic signed [Q_W-1:0] exp_o
);

  state_t                state;
  logic signed [Q_W-1:0] x;
  logic signed [Q_W-1:0] y;
  logic signed [Q_W-1:0] z;
  logic                  s_pos;
  logic                  id;
  logic                  last;
  logic [4:0]            step;
  logic [3:0]            idx;
  logic                  rep;

  logic [1:0]            pick;
  logic signed [Q_W-1:0] ang_sel;
  logic signed [Q_W-1:0] gain;
  logic signed [Q_W-1:0] atanh;
  logic signed [Q_W-1:0] x_n;
  logic signed [Q_W-1:0] y_n;
  logic signed [Q_W-1:0] z_n;
  logic                  s_n;
  logic signed [Q_W:0]   sum;
  logic signed [Q_W-1:0] exp_sat;

  // on a tie, serve whoever was not granted last
  always_comb begin
    pick = 2'b00;
    if (req0 && req1)
      pick = last ? 2'b01 : 2'b10;
    else if (req0)
      pick = 2'b01;
    else if (req1)
      pick = 2'b10;
  end

  assign gnt     = (state == IDLE) ? pick : 2'b00;
  assign ang_sel = gnt[1] ? angle1 : angle0;

  always_comb begin
    gain  = PRE_GAIN[step[2:0]];
    atanh = PRE_ATANH[step[2:0]];
    if (state == MAIN) begin
      gain  = MAIN_GAIN[idx];
      atanh = MAIN_ATANH[idx];
    end
  end

  cordic_hyp_step u_step (
    .x     (x),
    .y     (y),
    .z     (z),
    .s_pos (s_pos),
    .gain  (gain),
    .atanh (atanh),
    .x_n   (x_n),
    .y_n   (y_n),
    .z_n   (z_n),
    .s_n   (s_n)
  );

  assign sum     = 33'(x) + 33'(y);
  assign exp_sat = (sum[Q_W] != sum[Q_W-1]) ? (sum[Q_W] ? 32'sh80000000 : 32'sh7FFFFFFF)
                                            : sum[Q_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      x         <= '0;
      y         <= '0;
      z         <= '0;
      s_pos     <= 1'b0;
      id        <= 1'b0;
      last      <= 1'b1;
      step      <= '0;
      idx       <= '0;
      rep       <= 1'b0;
      busy      <= 1'b0;
      res_valid <= 1'b0;
      res_id    <= 1'b0;
      cosh      <= '0;
      sinh      <= '0;
      exp_o     <= '0;
    end else begin
      res_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (gnt != 2'b00) begin
            x     <= KINV_Q16;
            y     <= '0;
            z     <= ang_sel;
            s_pos <= ~ang_sel[Q_W-1];
            id    <= gnt[1];
            last  <= gnt[1];
            step  <= '0;
            idx   <= '0;
            rep   <= 1'b0;
            busy  <= 1'b1;
            state <= PRE;
          end
        end
        PRE: begin
          x     <= x_n;
          y     <= y_n;
          z     <= z_n;
          s_pos <= s_n;
          step  <= step + 5'd1;
          if (step == 5'(PRE_STEPS - 1))
            state <= MAIN;
        end
        MAIN: begin
          x     <= x_n;
          y     <= y_n;
          z     <= z_n;
          s_pos <= s_n;
          step  <= step + 5'd1;
          // indices 3 and 12 are run a second time before advancing
          if (((idx == REP_IDX_A) || (idx == REP_IDX_B)) && !rep) begin
            rep <= 1'b1;
          end else begin
            rep <= 1'b0;
            idx <= idx + 4'd1;
          end
          if (step == 5'(PRE_STEPS + MAIN_STEPS - 1))
            state <= DONE;
        end
        DONE: begin
          cosh      <= x;
          sinh      <= y;
          exp_o     <= exp_sat;
          res_id    <= id;
          res_valid <= 1'b1;
          busy      <= 1'b0;
          step      <= '0;
          idx       <= '0;
          rep       <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_hyp_sched.sv
// Randomized bench for cordic_hyp_sched against a real-arithmetic exp() reference.
module tb_cordic_hyp_sched;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               req0 = 1'b0;
  logic               req1 = 1'b0;
  logic signed [31:0] angle0 = '0;
  logic signed [31:0] angle1 = '0;
  logic [1:0]         gnt;
  logic               busy;
  logic               res_valid;
  logic               res_id;
  logic signed [31:0] cosh;
  logic signed [31:0] sinh;
  logic signed [31:0] exp_o;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int rv_cnt = 0;
  int caps[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cordic_hyp_sched dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req0      (req0),
    .req1      (req1),
    .angle0    (angle0),
    .angle1    (angle1),
    .gnt       (gnt),
    .busy      (busy),
    .res_valid (res_valid),
    .res_id    (res_id),
    .cosh      (cosh),
    .sinh      (sinh),
    .exp_o     (exp_o)
  );

  task automatic chk(input string tag, input longint got, input longint want, input longint tol);
    longint d;
    total++;
    d = got - want;
    if (d < 0) d = -d;
    if (d > tol) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (tol %0d)", tag, got, want, tol);
    end
  endtask

  // reference: cosh/sinh/exp straight from exp(), scaled to Q16.16
  function automatic void model(input int ang, output longint c, output longint s, output longint e);
    real a, ep, em;
    a  = real'(ang) / 65536.0;
    ep = $exp(a);
    em = $exp(-a);
    c  = longint'((ep + em) * 32768.0);
    s  = longint'((ep - em) * 32768.0);
    e  = longint'(ep * 65536.0);
    if (e > 64'sd2147483647) e = 64'sd2147483647;
  endfunction

  // grant watcher: records capture edges, checks grants only happen while idle
  always @(negedge clk) begin
    #3;
    if (rst_n) begin
      if (gnt != 2'b00) begin
        caps.push_back(cyc + 1);
        chk("gnt_while_busy", busy, 0, 0);
        chk("gnt_onehot", $countones(gnt), 1, 0);
      end
      if (res_valid) rv_cnt++;
    end
  end

  task automatic wait_result(input string tag);
    int t;
    t = 0;
    while (!res_valid && t < 40) begin
      @(negedge clk); #1; t++;
    end
    chk({tag, " res_valid_seen"}, res_valid, 1, 0);
  endtask

  task automatic check_res(input string tag, input bit c, input int cap,
                           input longint ec, input longint es, input longint ee, input longint tol);
    chk({tag, " latency"}, cyc - cap, 25, 0);
    chk({tag, " res_id"}, res_id, c, 0);
    chk({tag, " cosh"}, cosh, ec, tol);
    chk({tag, " sinh"}, sinh, es, tol);
    chk({tag, " exp"}, exp_o, ee, tol);
    $display("txn %s: client=%0d cosh=%0d sinh=%0d exp=%0d", tag, res_id, cosh, sinh, exp_o);
  endtask

  task automatic serve(input bit c, input int ang, input longint ec, input longint es,
                       input longint ee, input longint tol, input string tag);
    int t, cap;
    @(negedge clk);
    if (c) begin angle1 = ang; req1 = 1'b1; end
    else   begin angle0 = ang; req0 = 1'b1; end
    #1;
    t = 0;
    while (gnt == 2'b00 && t < 100) begin
      @(negedge clk); #1; t++;
    end
    chk({tag, " gnt"}, gnt, c ? 2 : 1, 0);
    cap = cyc + 1;
    @(negedge clk);
    if (c) req1 = 1'b0; else req0 = 1'b0;
    #1;
    wait_result(tag);
    check_res(tag, c, cap, ec, es, ee, tol);
  endtask

  initial begin
    longint ec, es, ee, ec2, es2, ee2, tol;
    int a, b, cap, cap1, rv0, n0, got, t;
    bit c;

    // reset state
    repeat (3) @(negedge clk);
    #1;
    chk("rst gnt", gnt, 0, 0);
    chk("rst busy", busy, 0, 0);
    chk("rst res_valid", res_valid, 0, 0);
    chk("rst res_id", res_id, 0, 0);
    chk("rst cosh", cosh, 0, 0);
    chk("rst sinh", sinh, 0, 0);
    chk("rst exp", exp_o, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // fixed points
    serve(1'b0, 0,       65536,  0,      65536,  64, "zero");
    serve(1'b0, 65536,   101127, 77018,  178145, 64, "pos_one");
    serve(1'b1, -65536,  101127, -77018, 24109,  64, "neg_one");

    // simultaneous requests straight after reset
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    a = 40000; b = -90000;
    angle0 = a; angle1 = b; req0 = 1'b1; req1 = 1'b1;
    #1;
    chk("rr first gnt", gnt, 1, 0);
    cap = cyc + 1;
    @(negedge clk); req0 = 1'b0; #1;
    wait_result("rr_first");
    model(a, ec, es, ee);
    check_res("rr_first", 1'b0, cap, ec, es, ee, 64);
    chk("rr handoff gnt", gnt, 2, 0);
    cap1 = cyc + 1;
    @(negedge clk); req1 = 1'b0; #1;
    wait_result("rr_second");
    model(b, ec, es, ee);
    check_res("rr_second", 1'b1, cap1, ec, es, ee, 64);

    // reset in the middle of MAIN
    @(negedge clk);
    angle0 = 70000; req0 = 1'b1;
    #1;
    t = 0;
    while (gnt == 2'b00 && t < 50) begin @(negedge clk); #1; t++; end
    chk("abort gnt", gnt, 1, 0);
    @(negedge clk); req0 = 1'b0;
    repeat (15) @(negedge clk);
    #2; rst_n = 1'b0; #1;
    chk("abort busy", busy, 0, 0);
    chk("abort res_valid", res_valid, 0, 0);
    chk("abort cosh", cosh, 0, 0);
    chk("abort sinh", sinh, 0, 0);
    chk("abort exp", exp_o, 0, 0);
    chk("abort res_id", res_id, 0, 0);
    rv0 = rv_cnt;
    @(negedge clk);
    a = -30000;
    angle0 = a; req0 = 1'b1; rst_n = 1'b1;
    #1;
    chk("post-reset gnt", gnt, 1, 0);
    cap = cyc + 1;
    @(negedge clk); req0 = 1'b0;
    repeat (15) @(negedge clk);
    #4;
    chk("abort no res_valid", rv_cnt, rv0, 0);
    wait_result("post_reset");
    model(a, ec, es, ee);
    check_res("post_reset", 1'b0, cap, ec, es, ee, 64);

    // back-to-back from client 0 only
    a = int'($urandom_range(0, 196608)) - 98304;
    model(a, ec, es, ee);
    @(negedge clk);
    n0 = caps.size();
    angle0 = a; req0 = 1'b1;
    got = 0; t = 0;
    while (got < 3 && t < 200) begin
      @(negedge clk);
      if (caps.size() >= n0 + 3) req0 = 1'b0;
      #4;
      if (res_valid) begin
        got++;
        chk("b2b res_id", res_id, 0, 0);
        chk("b2b cosh", cosh, ec, 64);
        chk("b2b exp", exp_o, ee, 64);
        $display("txn b2b: client=%0d cosh=%0d sinh=%0d exp=%0d", res_id, cosh, sinh, exp_o);
      end
      t++;
    end
    req0 = 1'b0;
    chk("b2b results", got, 3, 0);
    chk("b2b grants", caps.size(), n0 + 3, 0);
    if (caps.size() >= n0 + 3) begin
      chk("b2b spacing1", caps[n0 + 1] - caps[n0], 26, 0);
      chk("b2b spacing2", caps[n0 + 2] - caps[n0 + 1], 26, 0);
    end

    // random clients and angles in (-2.5, 2.5)
    for (int i = 0; i < 8; i++) begin
      c = 1'($urandom_range(0, 1));
      a = int'($urandom_range(0, 327680)) - 163840;
      model(a, ec2, es2, ee2);
      tol = 64 + (ec2 + ee2) / 4096;
      serve(c, a, ec2, es2, ee2, tol, $sformatf("rand%0d", i));
    end

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cordic_hyp_sched.md
CORDIC_HYP_SCHED -- requirements
Module: cordic_hyp_sched

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-003 SHALL have ports req0 and req1, input, 1 bit each: client 0/1 request; held high until granted.
REQ-004 SHALL have ports angle0 and angle1, input, 32 bits signed Q16.16 each: client 0/1 argument.
REQ-005 SHALL have port gnt, output, 2 bits, one-hot or zero: grant; the granted client's angle is captured on this edge.
REQ-006 SHALL have port busy, output, 1 bit: high from the capture edge until the result is issued.
REQ-007 SHALL have port res_valid, output, 1 bit: one-cycle result strobe.
REQ-008 SHALL have port res_id, output, 1 bit: client owning the result.
REQ-009 SHALL have ports cosh, sinh and exp_o, output, 32 bits signed Q16.16 each: results, held until the next res_valid.

Function
REQ-010 SHALL implement FSM states IDLE, PRE, MAIN, DONE.
REQ-011 SHALL drive gnt combinationally only in IDLE, granting at most one client per cycle.
REQ-012 SHALL arbitrate round-robin: on simultaneous requests, grant the client not most recently granted; last-granted resets to 1, so client 0 wins first.
REQ-013 SHALL, on the capture edge, load x=KINV_Q16, y=0, z=granted angle, id=granted client, s=+1 if angle>=0 else -1, and go IDLE->PRE.
REQ-014 SHALL perform exactly one micro-rotation per cycle: x'=x+s*(y*t>>>16), y'=y+s*(x*t>>>16), z'=z-s*a, with products at 64 bits and arithmetic shift truncation to 32 bits.
REQ-015 SHALL set s for the next step to +1 if z'>0, else -1.
REQ-016 SHALL run PRE for 6 steps with k=0..5 using gain PRE_GAIN[k] and angle PRE_ATANH[k], then go to MAIN.
REQ-017 SHALL run MAIN over indices 0..15 using MAIN_GAIN[i] and MAIN_ATANH[i], executing indices 3 and 12 twice via a repeat flag, for 18 MAIN steps.
REQ-018 SHALL go to DONE after the last MAIN step; PRE+MAIN equals 24 step edges.
REQ-019 SHALL, on the DONE exit edge, register cosh=x, sinh=y, exp_o=sat32(x+y), set res_valid=1 for exactly one cycle, and return to IDLE.
REQ-020 SHALL assert res_valid exactly 25 edges after the capture edge; minimum spacing between capture edges is 26 cycles.
REQ-021 SHALL saturate exp_o to 0x7FFFFFFF or 0x80000000 on signed overflow and shall not wrap it.
REQ-022 SHALL ignore requests outside IDLE; a request dropped before grant is lost, with no side effect.

Reset
REQ-023 SHALL, while rst_n=0, asynchronously force state=IDLE, gnt=0, busy=0, res_valid=0, res_id=0, cosh=sinh=exp_o=0, counters=0, repeat flag=0, last-granted=1.
REQ-024 SHALL, on reset mid-operation, discard the computation, produce no res_valid, and accept a new grant on the first cycle after release.

Structure
REQ-025 SHALL place in shared package cordic_hyp_pkg: Q16.16 width constant, KINV_Q16, PRE_GAIN[0:5], PRE_ATANH[0:5], MAIN_GAIN[0:15], MAIN_ATANH[0:15], repeat indices 3 and 12, step counts 6 and 18, and the state enum.
REQ-026 SHALL instantiate one combinational sub-module cordic_hyp_step that computes x', y', z' and next-s from x, y, z, s, gain and atanh.

Verification
REQ-027 SHALL verify: req0 with angle0=0 -> gnt=01, res_valid 25 edges later, cosh=65536, sinh=0 and exp_o=65536, each within ±64 LSB.
REQ-028 SHALL verify: angle0=65536 (1.0) -> cosh≈101127, sinh≈77018 and exp_o≈178145, each within ±64 LSB.
REQ-029 SHALL verify: angle1=-65536 -> res_id=1, cosh≈101127, sinh≈-77018 and exp_o≈24109, each within ±64 LSB.
REQ-030 SHALL verify: req0 and req1 both high after reset -> client 0 is served first; client 1 is granted on the first IDLE cycle after that res_valid; the second res_id=1.
REQ-031 SHALL verify: rst_n pulsed low on MAIN step 10 -> no res_valid, all outputs 0, busy=0, and the next request completes with correct values.
REQ-032 SHALL verify: back-to-back requests from client 0 only -> capture edges exactly 26 cycles apart, and gnt never asserts while busy=1.
